// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: drains a FIFO word by word and serializes it as start, LSB-first data, optional even parity, stop
module fifo_serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  FIFO_empty,
    input  logic [DATA_WIDTH-1:0] FIFO_data_out,
    output logic                  read_enable,
    output logic                  tx,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  frames_sent
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, START, DATA, PAR, STOP} state_t;

    state_t                r_state;
    logic [TW-1:0]         r_timer;
    logic [BW-1:0]         r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par;
    logic                  r_tx;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  w_bit_end;

    assign w_bit_end   = r_timer == '0;
    assign read_enable = Enable && r_state == REQ;
    assign done        = Enable && r_state == STOP && w_bit_end;
    assign busy        = r_state != IDLE;
    assign tx          = r_tx;
    assign frames_sent = r_count;

    // Frame sequencer; tx is loaded with the level of the state being entered
    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_count <= '0;
        end else if (Enable) begin
            if (done)
                r_count <= r_count + 1'b1;
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (!FIFO_empty)
                        r_state <= REQ;
                end
                REQ: r_state <= WAIT;
                WAIT: begin
                    r_shift <= FIFO_data_out;
                    r_par   <= ^FIFO_data_out;
                    r_timer <= TMAX;
                    r_tx    <= 1'b0;
                    r_state <= START;
                end
                START: begin
                    if (w_bit_end) begin
                        r_timer <= TMAX;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end else
                        r_timer <= r_timer - 1'b1;
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_timer <= TMAX;
                        if (r_bit == BLAST) begin
                            r_tx    <= PARITY_EN != 0 ? r_par : 1'b1;
                            r_state <= PARITY_EN != 0 ? PAR : STOP;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else
                        r_timer <= r_timer - 1'b1;
                end
                PAR: begin
                    if (w_bit_end) begin
                        r_timer <= TMAX;
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                    end else
                        r_timer <= r_timer - 1'b1;
                end
                STOP: begin
                    if (w_bit_end)
                        r_state <= FIFO_empty ? IDLE : REQ;
                    else
                        r_timer <= r_timer - 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb_fifo_serial_tx: directed checks of the FIFO serial transmitter
module tb_fifo_serial_tx;
    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Enable = 1'b1;
    logic        FIFO_empty;
    logic [7:0]  fdout = 8'h00;
    logic        read_enable, tx, busy, done;
    logic [15:0] frames_sent;
    logic        e2 = 1'b1;
    logic [7:0]  d2 = 8'h96;
    logic        re2, tx2, busy2, done2;
    logic [15:0] fs2;

    logic [7:0] mem [8];
    int wp = 0, rp = 0;
    int vec = 0, errs = 0;
    int n = 0;
    logic tx_l [512];
    logic re_l [512];
    logic dn_l [512];
    logic bs_l [512];
    logic tx2_l [512];
    logic re2_l [512];
    logic dn2_l [512];

    fifo_serial_tx dut (
        .clk(clk), .Reset(Reset), .Enable(Enable), .FIFO_empty(FIFO_empty),
        .FIFO_data_out(fdout), .read_enable(read_enable), .tx(tx), .busy(busy),
        .done(done), .frames_sent(frames_sent)
    );

    fifo_serial_tx #(.PARITY_EN(0)) dut2 (
        .clk(clk), .Reset(Reset), .Enable(Enable), .FIFO_empty(e2),
        .FIFO_data_out(d2), .read_enable(re2), .tx(tx2), .busy(busy2),
        .done(done2), .frames_sent(fs2)
    );

    always #5 clk = ~clk;

    assign FIFO_empty = (wp == rp);

    always @(posedge clk)
        if (read_enable) begin
            fdout <= mem[rp % 8];
            rp    <= rp + 1;
        end

    task automatic push(input logic [7:0] d);
        mem[wp % 8] = d;
        wp = wp + 1;
    endtask

    task automatic capture(input int c);
        for (int i = 0; i < c; i++) begin
            @(negedge clk);
            tx_l[n]  = tx;
            re_l[n]  = read_enable;
            dn_l[n]  = done;
            bs_l[n]  = busy;
            tx2_l[n] = tx2;
            re2_l[n] = re2;
            dn2_l[n] = done2;
            n = n + 1;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        repeat (2) @(negedge clk);
        Reset = 1'b1;
        n = 0;
    endtask

    task automatic test_reset();
        push(8'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec++;
            if (tx !== 1'b1 || read_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || frames_sent !== 16'd0) begin
                errs++;
                $display("FAIL reset_state cycle %0d: tx=%b re=%b busy=%b done=%b fs=%0d, want 1 0 0 0 0",
                         i, tx, read_enable, busy, done, frames_sent);
            end
        end
    endtask

    task automatic test_single();
        logic [10:0] ex;
        int cnt, s;
        bit ok;
        ex = {1'b1, 1'b0, 8'hA5, 1'b0};
        Reset = 1'b1;
        n = 0;
        capture(70);
        cnt = 0;
        s = -1;
        for (int i = 0; i < 70; i++) begin
            if (re_l[i]) cnt++;
            if (s < 0 && tx_l[i] === 1'b0) s = i;
        end
        vec++;
        if (cnt !== 1) begin errs++; $display("FAIL single_re_count got %0d want 1", cnt); end
        vec++;
        if (re_l[0] !== 1'b1 || bs_l[0] !== 1'b1) begin
            errs++; $display("FAIL single_req_cycle re=%b busy=%b want 1 1", re_l[0], bs_l[0]);
        end
        vec++;
        if (s !== 2) begin errs++; $display("FAIL single_start_idx got %0d want 2", s); end
        for (int b = 0; b < 11; b++) begin
            ok = 1;
            for (int c = 0; c < 4; c++) if (tx_l[2 + 4*b + c] !== ex[b]) ok = 0;
            vec++;
            if (!ok) begin errs++; $display("FAIL single_bit%0d got %b want %b", b, tx_l[2 + 4*b], ex[b]); end
        end
        cnt = 0;
        for (int i = 0; i < 70; i++) if (dn_l[i]) cnt++;
        vec++;
        if (dn_l[45] !== 1'b1 || cnt !== 1) begin
            errs++; $display("FAIL single_done at45=%b count=%0d want 1 1", dn_l[45], cnt);
        end
        vec++;
        if (frames_sent !== 16'd1) begin errs++; $display("FAIL single_count got %0d want 1", frames_sent); end
        vec++;
        if (bs_l[46] !== 1'b0 || tx_l[46] !== 1'b1) begin
            errs++; $display("FAIL single_idle busy=%b tx=%b want 0 1", bs_l[46], tx_l[46]);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] ex [3];
        int st, cre, cdn, bad;
        ex[0] = {1'b1, 1'b0, 8'h00, 1'b0};
        ex[1] = {1'b1, 1'b0, 8'hFF, 1'b0};
        ex[2] = {1'b1, 1'b0, 8'h3C, 1'b0};
        do_reset();
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        capture(160);
        for (int f = 0; f < 3; f++) begin
            st = 2 + 46*f;
            bad = -1;
            for (int k = 0; k < 44; k++) if (bad < 0 && tx_l[st + k] !== ex[f][k/4]) bad = k;
            vec++;
            if (bad >= 0) begin
                errs++; $display("FAIL b2b_frame%0d cycle %0d got %b want %b", f, bad, tx_l[st + bad], ex[f][bad/4]);
            end
            vec++;
            if (tx_l[st + 36] !== 1'b0) begin errs++; $display("FAIL b2b_parity%0d got %b want 0", f, tx_l[st + 36]); end
            vec++;
            if (re_l[st - 2] !== 1'b1 || dn_l[st + 43] !== 1'b1) begin
                errs++; $display("FAIL b2b_pulses%0d re=%b done=%b want 1 1", f, re_l[st - 2], dn_l[st + 43]);
            end
            if (f < 2) begin
                vec++;
                if (tx_l[st + 44] !== 1'b1 || tx_l[st + 45] !== 1'b1 || bs_l[st + 44] !== 1'b1) begin
                    errs++; $display("FAIL b2b_gap%0d tx=%b%b busy=%b want 11 1", f, tx_l[st + 44], tx_l[st + 45], bs_l[st + 44]);
                end
            end
        end
        cre = 0;
        cdn = 0;
        for (int i = 0; i < 160; i++) begin
            if (re_l[i]) cre++;
            if (dn_l[i]) cdn++;
        end
        vec++;
        if (cre !== 3 || cdn !== 3) begin errs++; $display("FAIL b2b_counts re=%0d done=%0d want 3 3", cre, cdn); end
        vec++;
        if (frames_sent !== 16'd3) begin errs++; $display("FAIL b2b_frames got %0d want 3", frames_sent); end
        vec++;
        if (bs_l[138] !== 1'b0) begin errs++; $display("FAIL b2b_idle busy=%b want 0", bs_l[138]); end
    endtask

    task automatic test_empty();
        int cre, cbs, ctx;
        do_reset();
        capture(100);
        cre = 0; cbs = 0; ctx = 0;
        for (int i = 0; i < 100; i++) begin
            if (re_l[i]) cre++;
            if (bs_l[i]) cbs++;
            if (tx_l[i] !== 1'b1) ctx++;
        end
        vec++;
        if (cre !== 0) begin errs++; $display("FAIL empty_re got %0d pulses want 0", cre); end
        vec++;
        if (cbs !== 0 || ctx !== 0) begin errs++; $display("FAIL empty_idle busy=%0d txlow=%0d want 0 0", cbs, ctx); end
    endtask

    task automatic test_reset_mid();
        int cdn, cbs;
        do_reset();
        push(8'h5A);
        capture(20);
        vec++;
        if (tx_l[18] !== 1'b1 || bs_l[18] !== 1'b1) begin
            errs++; $display("FAIL mid_bit3 tx=%b busy=%b want 1 1", tx_l[18], bs_l[18]);
        end
        Reset = 1'b0;
        capture(1);
        vec++;
        if (tx_l[20] !== 1'b1 || bs_l[20] !== 1'b0 || dn_l[20] !== 1'b0 || frames_sent !== 16'd0) begin
            errs++; $display("FAIL mid_reset tx=%b busy=%b done=%b fs=%0d want 1 0 0 0", tx_l[20], bs_l[20], dn_l[20], frames_sent);
        end
        Reset = 1'b1;
        capture(60);
        cdn = 0; cbs = 0;
        for (int i = 21; i < 81; i++) begin
            if (dn_l[i]) cdn++;
            if (bs_l[i]) cbs++;
        end
        vec++;
        if (cdn !== 0 || cbs !== 0 || frames_sent !== 16'd0) begin
            errs++; $display("FAIL mid_after done=%0d busy=%0d fs=%0d want 0 0 0", cdn, cbs, frames_sent);
        end
    endtask

    task automatic test_enable();
        logic [10:0] ex;
        int bad, idx, cdn;
        bit ok;
        ex = {1'b1, 1'b0, 8'hC3, 1'b0};
        do_reset();
        push(8'hC3);
        capture(4);
        Enable = 1'b0;
        capture(7);
        Enable = 1'b1;
        capture(60);
        ok = 1;
        for (int i = 4; i < 11; i++) if (tx_l[i] !== 1'b0 || bs_l[i] !== 1'b1 || dn_l[i] !== 1'b0) ok = 0;
        vec++;
        if (!ok) begin errs++; $display("FAIL enable_freeze tx=%b busy=%b want 0 1", tx_l[7], bs_l[7]); end
        bad = -1;
        for (int k = 0; k < 44; k++) begin
            idx = k < 2 ? 2 + k : 9 + k;
            if (bad < 0 && tx_l[idx] !== ex[k/4]) bad = k;
        end
        vec++;
        if (bad >= 0) begin errs++; $display("FAIL enable_bits cycle %0d got wrong level want %b", bad, ex[bad/4]); end
        cdn = 0;
        for (int i = 0; i < 71; i++) if (dn_l[i]) cdn++;
        vec++;
        if (dn_l[52] !== 1'b1 || cdn !== 1) begin errs++; $display("FAIL enable_done at52=%b count=%0d want 1 1", dn_l[52], cdn); end
        vec++;
        if (frames_sent !== 16'd1 || bs_l[53] !== 1'b0) begin
            errs++; $display("FAIL enable_end fs=%0d busy=%b want 1 0", frames_sent, bs_l[53]);
        end
    endtask

    task automatic test_nopar();
        logic [9:0] ex;
        int s, d, bad;
        ex = {1'b1, 8'h96, 1'b0};
        do_reset();
        e2 = 1'b0;
        capture(1);
        vec++;
        if (re2_l[0] !== 1'b1) begin errs++; $display("FAIL nopar_req got %b want 1", re2_l[0]); end
        e2 = 1'b1;
        capture(60);
        s = -1; d = -1;
        for (int i = 0; i < 61; i++) begin
            if (s < 0 && tx2_l[i] === 1'b0) s = i;
            if (d < 0 && dn2_l[i] === 1'b1) d = i;
        end
        vec++;
        if (s !== 2 || d - s + 1 !== 40) begin errs++; $display("FAIL nopar_len start=%0d len=%0d want 2 40", s, d - s + 1); end
        bad = -1;
        for (int k = 0; k < 40; k++) if (bad < 0 && tx2_l[2 + k] !== ex[k/4]) bad = k;
        vec++;
        if (bad >= 0) begin errs++; $display("FAIL nopar_bits cycle %0d got %b want %b", bad, tx2_l[2 + bad], ex[bad/4]); end
        vec++;
        if (fs2 !== 16'd1) begin errs++; $display("FAIL nopar_count got %0d want 1", fs2); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_empty();
        test_reset_mid();
        test_enable();
        test_nopar();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
